// File: rtl/accumulate_yn.sv
// Final accumulation stage of the MSDAP datapath: folds the sixteen u_j partial
// sums (highest j first) into y(n) by Horner shift-add and strobes the result.
module accumulate_yn #(
  parameter int DATA_W     = 40,
  parameter int NUM_GROUPS = 16
) (
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              uj_valid,
  input  logic [DATA_W-1:0] uj_in,
  output logic              uj_ready,
  output logic [3:0]        j_idx,
  output logic              busy,
  output logic [DATA_W-1:0] y_out,
  output logic              y_valid
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_GROUPS - 1);

  state_t                   state, stateNext;
  logic        [DATA_W-1:0] acc, accNext;
  logic        [3:0]        jIdx, jIdxNext;
  logic signed [DATA_W:0]   sum;
  logic        [DATA_W-1:0] stepVal;
  logic                     loadY;

  // One extra bit keeps the add exact; the arithmetic shift floors toward -inf.
  assign sum     = $signed({uj_in[DATA_W-1], uj_in}) + $signed({acc[DATA_W-1], acc});
  assign stepVal = DATA_W'(sum >>> 1);

  always_comb begin
    stateNext = state;
    accNext   = acc;
    jIdxNext  = jIdx;
    loadY     = 1'b0;
    uj_ready  = (state == ACCUM);
    busy      = (state == ACCUM);
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = ACCUM;
          accNext   = '0;
          jIdxNext  = LAST_IDX;
        end
      end
      ACCUM: begin
        // start outranks any u_j presented in the same cycle, including the last one.
        if (start) begin
          accNext  = '0;
          jIdxNext = LAST_IDX;
        end else if (uj_valid) begin
          if (jIdx == '0) begin
            loadY     = 1'b1;
            stateNext = IDLE;
            accNext   = '0;
            jIdxNext  = LAST_IDX;
          end else begin
            accNext  = stepVal;
            jIdxNext = jIdx - 4'd1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      jIdx    <= LAST_IDX;
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      state   <= stateNext;
      acc     <= accNext;
      jIdx    <= jIdxNext;
      y_valid <= loadY;
      if (loadY) y_out <= stepVal;
    end
  end

  assign j_idx = jIdx;

endmodule
